seven_seg_mux_driver: RTL

//  Parametrised multiplexed seven-segment driver; next generation of the 8-digit hex display driver.
//  - Scans NUM_DIGITS hex digits onto shared segment lines with per-digit anodes.
//  - Double-buffered load: the displayed value changes only at a frame boundary, so there is no tearing.
//  - Adds per-digit decimal points and PWM brightness.
//  - Sits between the ALU result path and the board display pins.

---
 rtl/seven_seg_pkg.sv | 34 +++
 rtl/seven_seg_decoder.sv | 15 +
 rtl/seven_seg_mux_driver.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared types and glyph table for the multiplexed seven-segment driver.
//   seg_t      : segment vector {g,f,e,d,c,b,a}, active-high inside the design
//   SEG_BLANK  : all segments off (active-high)
//   hex_to_seg : nibble -> active-high glyph, full hex with lower-case b and d
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t seg;
        case (nibble)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: combinational nibble -> active-high segment pattern.
//   nibble : hex digit to show
//   blank  : 1 forces all segments off
//   seg    : {g,f,e,d,c,b,a}, active-high
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output seg_t       seg
);

    assign seg = blank ? SEG_BLANK : hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_mux_driver.sv
// seven_seg_mux_driver: multiplexed NUM_DIGITS hex display driver with
// double-buffered load, per-digit decimal points and PWM brightness.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : capture number/dp_in into the pending buffer
//   number       : hex value, digit i = number[4i+3:4i]
//   dp_in        : decimal point per digit (1 = lit)
//   brightness   : anode on while pwm_cnt <= brightness
//   seg_out      : {g,f,e,d,c,b,a} of the selected digit (polarity per SEG_ACT_LOW)
//   dp_out       : decimal point of the selected digit (polarity per SEG_ACT_LOW)
//   an           : digit enables, at most one active (polarity per AN_ACT_LOW)
//   frame_start  : one-cycle pulse alongside the outputs of digit 0
//   pending      : a load is captured but not yet displayed
// Build option: define SEG_LZ_BLANK_EN to blank leading zero digits
// (digit 0 is never blanked; dp still shows).
module seven_seg_mux_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_W    = 4,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] number,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TICK_W = $clog2(REFRESH_DIV);

    // XOR masks that turn an active-high value into the pin polarity;
    // they are also the "off" values driven during reset.
    localparam seg_t                  SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACT_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACT_LOW != 0}};

    logic [TICK_W-1:0]       tick_cnt, tick_nxt;
    logic [IDX_W-1:0]        digit_idx, idx_nxt;
    logic [BRIGHT_W-1:0]     pwm_cnt, pwm_nxt;
    logic [4*NUM_DIGITS-1:0] disp_num, pend_num, num_nxt;
    logic [NUM_DIGITS-1:0]   disp_dp, pend_dp, dp_nxt;
    logic                    tick_end, last_digit, wrap;

    logic [NUM_DIGITS-1:0]   blank;
    seg_t                    seg_dig [NUM_DIGITS];
    seg_t                    seg_sel;
    logic                    dp_sel;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic                    pwm_on;

    // Scan counters and buffer commit
    assign tick_end   = (tick_cnt == TICK_W'(REFRESH_DIV - 1));
    assign last_digit = (digit_idx == IDX_W'(NUM_DIGITS - 1));
    assign wrap       = tick_end && last_digit;

    assign tick_nxt = tick_end ? '0 : tick_cnt + 1'b1;
    assign idx_nxt  = !tick_end ? digit_idx : (last_digit ? '0 : digit_idx + 1'b1);
    assign pwm_nxt  = pwm_cnt + 1'b1;

    // The output registers are fed from next-state values so that a new digit's
    // segments, dp and anode, plus a freshly committed buffer, all land together.
    assign num_nxt = (wrap && pending) ? pend_num : disp_num;
    assign dp_nxt  = (wrap && pending) ? pend_dp  : disp_dp;

`ifdef SEG_LZ_BLANK_EN
    // Walk from the MSB digit down; blanking stops at the first non-zero digit.
    always_comb begin
        logic lead;
        lead  = 1'b1;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead     = lead && (num_nxt[4*i +: 4] == 4'h0);
            blank[i] = lead;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seven_seg_decoder u_dec (
            .nibble (num_nxt[4*g +: 4]),
            .blank  (blank[g]),
            .seg    (seg_dig[g])
        );
    end

    always_comb begin
        seg_sel = SEG_BLANK;
        dp_sel  = 1'b0;
        an_sel  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                seg_sel   = seg_dig[i];
                dp_sel    = dp_nxt[i];
                an_sel[i] = 1'b1;
            end
        end
    end

    assign pwm_on = (pwm_nxt <= brightness);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            digit_idx <= '0;
            pwm_cnt   <= '0;
            disp_num  <= '0;
            disp_dp   <= '0;
            pend_num  <= '0;
            pend_dp   <= '0;
            pending   <= 1'b0;
        end else begin
            tick_cnt  <= tick_nxt;
            digit_idx <= idx_nxt;
            pwm_cnt   <= pwm_nxt;
            disp_num  <= num_nxt;
            disp_dp   <= dp_nxt;
            // A load on the boundary cycle wins over the clear: the commit above
            // already took the old pending value.
            if (load) begin
                pend_num <= number;
                pend_dp  <= dp_in;
                pending  <= 1'b1;
            end else if (wrap) begin
                pending  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out     <= SEG_OFF;
            dp_out      <= DP_OFF;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            seg_out     <= seg_sel ^ SEG_OFF;
            dp_out      <= dp_sel ^ DP_OFF;
            an          <= (pwm_on ? an_sel : '0) ^ AN_OFF;
            frame_start <= wrap;
        end
    end

endmodule
